div_arbiter: RTL and testbench
==============================

DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 64: maximum WAIT-state cycles allowed before fin is treated as lost.
REQ-002 clk  in  1  single clock, all state on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 req  in  2  per-requester request level, bit i = requester i.
REQ-005 dvd0, dvd1  in  16 each  dividend of requester 0 / 1, held stable while req[i]=1.
REQ-006 dvs0, dvs1  in  8 each  divisor of requester 0 / 1, held stable while req[i]=1.
REQ-007 done  out  2  one-cycle completion pulse, bit i = requester i.
REQ-008 quo, rem  out  8 each  result, valid only in the cycle done!=0.
REQ-009 err  out  1  result invalid (overflow/divide-by-zero or timeout), valid with done.
REQ-010 begin_div  out  1  start strobe to the shared divider.
REQ-011 in_bus  out  8  operand bus to the divider.
REQ-012 fin  in  1  divider finished; quotient on out_bus this cycle.
REQ-013 out_bus  in  8  divider result bus.

Function
REQ-014 The block SHALL use states IDLE, START, LD_HI, LD_LO, LD_DIV, WAIT, CAP_R, RESP.
REQ-015 IDLE: if req!=0, grant one requester via round-robin, latch its dvd/dvs, and leave IDLE next cycle; req is sampled only in IDLE.
REQ-016 Round-robin: pointer starts at 0; if both request, grant pointer; after any grant, pointer = other requester.
REQ-017 Precheck at grant: if dvd[15:8] >= dvs (covers dvs=0), go to RESP with err=1, quo=8'hFF, rem=8'hFF; begin_div never asserts.
REQ-018 Otherwise IDLE->START: begin_div=1, in_bus=0 for exactly one cycle.
REQ-019 LD_HI, LD_LO, LD_DIV: in_bus = dvd[15:8], dvd[7:0], dvs respectively, one cycle each, begin_div=0.
REQ-020 WAIT: in_bus=0; cycle counter increments from 0; fin=1 captures quo=out_bus and goes to CAP_R.
REQ-021 CAP_R: captures rem=out_bus (cycle after fin), goes to RESP.
REQ-022 WAIT timeout: counter reaching TIMEOUT without fin goes to RESP with err=1, quo=0, rem=0.
REQ-023 RESP: done[granted]=1 for one cycle, err as determined, then IDLE.
REQ-024 fin outside WAIT SHALL be ignored.
REQ-025 A requester keeping req high through the cycle after done is treated as a new request.
REQ-026 Minimum latency grant-to-done: 1 cycle (precheck error); normal path 6 cycles + fin delay.
REQ-027 begin_div, in_bus, done, err, quo, rem SHALL be registered outputs.

Reset
REQ-028 rst=1 SHALL immediately force state IDLE, pointer 0, counter 0, begin_div=0, in_bus=0, done=0, err=0, quo=0, rem=0.
REQ-029 Reset mid-operation abandons the transfer; no done is issued for it.

Structure
REQ-030 Package div_arb_pkg SHALL hold the state enum, the 3-byte load-count constant and the error result value 8'hFF.
REQ-031 The round-robin decision SHALL be a sub-module rr_arb2 (req[1:0], pointer -> one-hot grant).

Verification
REQ-032 req=01, dvd0=16'h03E8, dvs0=7, divider model fin after 10 cycles with 142 then 6 -> in_bus 00,03,E8,07; done=01, quo=142, rem=6, err=0.
REQ-033 req=11 held with valid operands -> grants alternate 0,1,0,1; no requester starved.
REQ-034 dvd1=16'h0A00, dvs1=8'h05 (overflow) and dvs1=0 -> done=10 one cycle after grant, err=1, quo=rem=FF, begin_div never high.
REQ-035 TIMEOUT=64, fin never asserted -> done after 64 WAIT cycles, err=1, quo=rem=0.
REQ-036 rst pulsed during WAIT -> all outputs 0 asynchronously, no done; next request completes normally.
REQ-037 fin pulse while IDLE -> no state change, no done.

Source files
------------

// File: rtl/div_arb_pkg.sv
// rtl/div_arb_pkg.sv - shared types and constants for the two-requester divider arbiter
package div_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        LD_HI,
        LD_LO,
        LD_DIV,
        WAIT,
        CAP_R,
        RESP
    } state_t;

    // Operand bytes streamed to the divider after the start strobe: dvd hi, dvd lo, dvs.
    localparam int LOAD_BYTES = 3;

    // Quotient/remainder reported for a request rejected before reaching the divider.
    localparam logic [7:0] ERR_RESULT = 8'hFF;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant decision
// Ports:
//   req   in  2  request bits, bit i = requester i
//   ptr   in  1  requester favoured when both request
//   grant out 2  one-hot grant (zero when nothing requests)
module rr_arb2
    import div_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (req == 2'b11) begin
            grant = ptr ? 2'b10 : 2'b01;
        end else begin
            // A single requester (or none) is already one-hot.
            grant = req;
        end
    end

endmodule

// File: rtl/div_arbiter.sv
// rtl/div_arbiter.sv - shares one byte-serial divider between two requesters
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   req[1:0]          request level per requester
//   dvd0/dvd1, dvs0/dvs1  operands of requester 0 / 1
//   done[1:0]         one-cycle completion pulse for the served requester
//   quo, rem, err     result and error flag, valid with done
//   begin_div, in_bus start strobe and operand bus to the divider
//   fin, out_bus      divider finish strobe and result bus
module div_arbiter
    import div_arb_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic [15:0] dvd0,
    input  logic [15:0] dvd1,
    input  logic [7:0]  dvs0,
    input  logic [7:0]  dvs1,
    output logic [1:0]  done,
    output logic [7:0]  quo,
    output logic [7:0]  rem,
    output logic        err,
    output logic        begin_div,
    output logic [7:0]  in_bus,
    input  logic        fin,
    input  logic [7:0]  out_bus
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t          state_q, state_d;
    logic            ptr_q, ptr_d;
    logic [1:0]      gnt_q, gnt_d;
    logic [1:0]      grant;
    logic [15:0]     dvd_q;
    logic [7:0]      dvs_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [15:0]     sel_dvd;
    logic [7:0]      sel_dvs;
    logic            precheck_fail;
    logic [7:0]      load_bytes [LOAD_BYTES];

    logic            begin_d, err_d;
    logic [7:0]      in_bus_d, quo_d, rem_d;
    logic [1:0]      done_d;

    rr_arb2 u_rr (
        .req   (req),
        .ptr   (ptr_q),
        .grant (grant)
    );

    // Operands of whichever requester the arbiter picks this cycle.
    assign sel_dvd = grant[1] ? dvd1 : dvd0;
    assign sel_dvs = grant[1] ? dvs1 : dvs0;

    // The quotient only fits in 8 bits when the high dividend byte is below the
    // divisor; this also catches a zero divisor.
    assign precheck_fail = (sel_dvd[15:8] >= sel_dvs);

    always_comb begin
        load_bytes[0] = dvd_q[15:8];
        load_bytes[1] = dvd_q[7:0];
        load_bytes[2] = dvs_q;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        quo_d   = quo;
        rem_d   = rem;

        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    gnt_d = grant;
                    ptr_d = grant[0];
                    if (precheck_fail) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                        quo_d   = ERR_RESULT;
                        rem_d   = ERR_RESULT;
                    end else begin
                        state_d = START;
                    end
                end
            end
            START:  state_d = LD_HI;
            LD_HI:  state_d = LD_LO;
            LD_LO:  state_d = LD_DIV;
            LD_DIV: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                // fin wins over a timeout landing in the same cycle.
                if (fin) begin
                    quo_d   = out_bus;
                    state_d = CAP_R;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    quo_d   = 8'h00;
                    rem_d   = 8'h00;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CAP_R: begin
                rem_d   = out_bus;
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Divider-side and response outputs are registered from the next state.
        begin_d  = (state_d == START);
        done_d   = (state_d == RESP) ? gnt_d : 2'b00;
        case (state_d)
            LD_HI:   in_bus_d = load_bytes[0];
            LD_LO:   in_bus_d = load_bytes[1];
            LD_DIV:  in_bus_d = load_bytes[2];
            default: in_bus_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= 1'b0;
            gnt_q     <= 2'b00;
            cnt_q     <= '0;
            dvd_q     <= 16'h0000;
            dvs_q     <= 8'h00;
            begin_div <= 1'b0;
            in_bus    <= 8'h00;
            done      <= 2'b00;
            err       <= 1'b0;
            quo       <= 8'h00;
            rem       <= 8'h00;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            cnt_q     <= cnt_d;
            if (state_q == IDLE && req != 2'b00) begin
                dvd_q <= sel_dvd;
                dvs_q <= sel_dvs;
            end
            begin_div <= begin_d;
            in_bus    <= in_bus_d;
            done      <= done_d;
            err       <= err_d;
            quo       <= quo_d;
            rem       <= rem_d;
        end
    end

endmodule

// File: tb/tb_div_arbiter.sv
// tb/tb_div_arbiter.sv - directed self-checking bench for div_arbiter
module tb_div_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [15:0] dvd0 = 16'h0000;
    logic [15:0] dvd1 = 16'h0000;
    logic [7:0]  dvs0 = 8'h00;
    logic [7:0]  dvs1 = 8'h00;
    logic [1:0]  done;
    logic [7:0]  quo;
    logic [7:0]  rem;
    logic        err;
    logic        begin_div;
    logic [7:0]  in_bus;
    logic        fin = 1'b0;
    logic [7:0]  out_bus = 8'h00;

    int total = 0;
    int bad   = 0;

    div_arbiter #(.TIMEOUT(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .dvd0      (dvd0),
        .dvd1      (dvd1),
        .dvs0      (dvs0),
        .dvs1      (dvs1),
        .done      (done),
        .quo       (quo),
        .rem       (rem),
        .err       (err),
        .begin_div (begin_div),
        .in_bus    (in_bus),
        .fin       (fin),
        .out_bus   (out_bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Divider model: waits for begin_div, collects the three operand bytes,
    // then after 'delay' cycles returns quotient on fin and remainder next cycle.
    // Returns at the negedge where the arbiter's done should be visible.
    task automatic run_divider(input int delay, output logic [7:0] b0, output logic [7:0] b1,
                               output logic [7:0] b2, output logic [7:0] b3,
                               output logic bd_hi, output logic seen);
        logic [15:0] dd;
        logic [7:0]  q, r;
        seen = 1'b0;
        b0 = 8'h00; b1 = 8'h00; b2 = 8'h00; b3 = 8'h00; bd_hi = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (begin_div) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        if (!seen) return;
        b0 = in_bus;
        tick(); b1 = in_bus; bd_hi = begin_div;
        tick(); b2 = in_bus;
        tick(); b3 = in_bus;
        dd = {b1, b2};
        q  = (b3 != 0) ? 8'(dd / 16'(b3)) : 8'h00;
        r  = (b3 != 0) ? 8'(dd % 16'(b3)) : 8'h00;
        repeat (delay) tick();
        fin = 1'b1; out_bus = q;
        tick();
        fin = 1'b0; out_bus = r;
        tick();
        out_bus = 8'h00;
    endtask

    task automatic wait_done(input int limit, output logic [1:0] d, output int cyc);
        d = 2'b00;
        cyc = 0;
        for (int i = 0; i < limit; i++) begin
            if (done != 2'b00) begin
                d = done;
                break;
            end
            tick();
            cyc++;
        end
    endtask

    initial begin
        logic [7:0] b0, b1, b2, b3;
        logic       bd_hi, seen, saw;
        logic [1:0] d;
        int         cyc;

        // Reset state, asserted from time 0.
        #1;
        check("rst_done", done, 2'b00);
        check("rst_err", err, 1'b0);
        check("rst_quo", quo, 8'h00);
        check("rst_rem", rem, 8'h00);
        check("rst_begin", begin_div, 1'b0);
        check("rst_inbus", in_bus, 8'h00);
        tick(); tick();
        rst = 1'b0;
        tick();

        // fin while idle must be ignored.
        fin = 1'b1; out_bus = 8'h55;
        saw = 1'b0;
        tick();
        fin = 1'b0; out_bus = 8'h00;
        for (int i = 0; i < 4; i++) begin
            saw = saw | (done != 2'b00) | begin_div;
            tick();
        end
        check("idle_fin_activity", saw, 1'b0);
        check("idle_fin_quo", quo, 8'h00);

        // Normal divide: 1000 / 7 = 142 rem 6, fin after 10 cycles.
        dvd0 = 16'h03E8; dvs0 = 8'h07; req = 2'b01;
        tick();
        req = 2'b00;
        run_divider(10, b0, b1, b2, b3, bd_hi, seen);
        check("n_begin_seen", seen, 1'b1);
        check("n_bus0", b0, 8'h00);
        check("n_bus_hi", b1, 8'h03);
        check("n_bus_lo", b2, 8'hE8);
        check("n_bus_dvs", b3, 8'h07);
        check("n_begin_one_cycle", bd_hi, 1'b0);
        wait_done(10, d, cyc);
        check("n_done", d, 2'b01);
        check("n_done_latency", cyc, 0);
        check("n_quo", quo, 8'd142);
        check("n_rem", rem, 8'd6);
        check("n_err", err, 1'b0);
        tick();
        check("n_done_pulse", done, 2'b00);

        // Reset pulsed during WAIT: outputs cleared asynchronously, no done.
        dvd0 = 16'h03E8; dvs0 = 8'h07; req = 2'b01;
        tick();
        req = 2'b00;
        repeat (8) tick();
        check("rw_quo_held", quo, 8'd142);
        #2 rst = 1'b1;
        #1;
        check("rw_quo", quo, 8'h00);
        check("rw_rem", rem, 8'h00);
        check("rw_done", done, 2'b00);
        check("rw_err", err, 1'b0);
        check("rw_begin", begin_div, 1'b0);
        check("rw_inbus", in_bus, 8'h00);
        tick();
        rst = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 20; i++) begin
            saw = saw | (done != 2'b00) | begin_div;
            tick();
        end
        check("rw_no_done", saw, 1'b0);

        // Both requesting continuously: grants alternate 0,1,0,1 from pointer 0.
        dvd0 = 16'h03E8; dvs0 = 8'h07;
        dvd1 = 16'h0123; dvs1 = 8'h10;
        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            run_divider(1 + 2 * i, b0, b1, b2, b3, bd_hi, seen);
            check("rr_begin_seen", seen, 1'b1);
            wait_done(10, d, cyc);
            if (i == 3) req = 2'b00;
            check("rr_grant", d, (i % 2 == 0) ? 2'b01 : 2'b10);
            check("rr_quo", quo, (i % 2 == 0) ? 8'd142 : 8'd18);
            check("rr_rem", rem, (i % 2 == 0) ? 8'd6 : 8'd3);
            check("rr_err", err, 1'b0);
        end
        repeat (3) tick();

        // Overflow precheck: 0x0A >= 5.
        dvd1 = 16'h0A00; dvs1 = 8'h05; req = 2'b10;
        tick();
        req = 2'b00;
        check("ovf_done", done, 2'b10);
        check("ovf_err", err, 1'b1);
        check("ovf_quo", quo, 8'hFF);
        check("ovf_rem", rem, 8'hFF);
        check("ovf_begin", begin_div, 1'b0);
        tick();
        check("ovf_done_pulse", done, 2'b00);
        check("ovf_begin2", begin_div, 1'b0);
        tick();

        // Divide by zero.
        dvd1 = 16'h0000; dvs1 = 8'h00; req = 2'b10;
        tick();
        req = 2'b00;
        check("dz_done", done, 2'b10);
        check("dz_err", err, 1'b1);
        check("dz_quo", quo, 8'hFF);
        check("dz_rem", rem, 8'hFF);
        check("dz_begin", begin_div, 1'b0);
        tick(); tick();

        // Boundary just below overflow: 0x04FF / 5 = 255 rem 4.
        dvd1 = 16'h04FF; dvs1 = 8'h05; req = 2'b10;
        tick();
        req = 2'b00;
        run_divider(3, b0, b1, b2, b3, bd_hi, seen);
        check("bnd_begin_seen", seen, 1'b1);
        wait_done(10, d, cyc);
        check("bnd_done", d, 2'b10);
        check("bnd_quo", quo, 8'hFF);
        check("bnd_rem", rem, 8'h04);
        check("bnd_err", err, 1'b0);
        tick(); tick();

        // Timeout: fin never arrives; done after 64 WAIT cycles.
        dvd0 = 16'h03E8; dvs0 = 8'h07; req = 2'b01;
        tick();
        req = 2'b00;
        check("to_begin", begin_div, 1'b1);
        repeat (3) tick();
        check("to_bus_dvs", in_bus, 8'h07);
        tick();
        wait_done(200, d, cyc);
        check("to_wait_cycles", cyc, 64);
        check("to_done", d, 2'b01);
        check("to_err", err, 1'b1);
        check("to_quo", quo, 8'h00);
        check("to_rem", rem, 8'h00);
        tick();
        check("to_done_pulse", done, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
